// File: rtl/axis_i2s_tx.sv
// ---------------------------------------------------------------------------
// axis_i2s_tx
//   AXI-Stream to I2S transmitter (DAC side of the stereo sample stream).
//   Collects one left/right word pair (last=0 then last=1), loads it into the
//   frame registers at the end of every LRCK period and shifts it out MSB
//   first with the standard one-SCLK I2S delay. SCLK = clk/8, LRCK = clk/512,
//   32 SCLK slots per channel, zero padded.
//
// Ports
//   clk           in   system / audio clock (MCLK rate)
//   reset         in   asynchronous active-high reset
//   s_axis_data   in   sample word, two's complement, DATA_WIDTH bits
//   s_axis_valid  in   AXIS valid
//   s_axis_ready  out  AXIS ready (registered)
//   s_axis_last   in   0 = left word, 1 = right word
//   tx_lrck       out  word select: 0 = left, 1 = right
//   tx_sclk       out  serial bit clock
//   tx_sdout      out  serial data, I2S format
//   underrun      out  1-clk pulse: frame started without a complete pair
//   sync_err      out  1-clk pulse: packet framing violation
// ---------------------------------------------------------------------------
module axis_i2s_tx #(
    parameter int DATA_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] s_axis_data,
    input  logic                  s_axis_valid,
    output logic                  s_axis_ready,
    input  logic                  s_axis_last,
    output logic                  tx_lrck,
    output logic                  tx_sclk,
    output logic                  tx_sdout,
    output logic                  underrun,
    output logic                  sync_err
);

    localparam logic [1:0] ST_FILL_L = 2'd0;
    localparam logic [1:0] ST_FILL_R = 2'd1;
    localparam logic [1:0] ST_FULL   = 2'd2;

    // Left shift that places the sample MSB at bit 30 of a 32-bit slot word.
    localparam int PAD = 31 - DATA_WIDTH;

    logic [8:0]            cnt_q,      cnt_d;
    logic [1:0]            state_q,    state_d;
    logic                  ready_q,    ready_d;
    logic [DATA_WIDTH-1:0] hold_l_q,   hold_l_d;
    logic [DATA_WIDTH-1:0] hold_r_q,   hold_r_d;
    logic [DATA_WIDTH-1:0] frame_l_q,  frame_l_d;
    logic [DATA_WIDTH-1:0] frame_r_q,  frame_r_d;
    logic                  sdout_q,    sdout_d;
    logic                  underrun_q, underrun_d;
    logic                  sync_err_q, sync_err_d;

    logic                  hs_s;
    logic [5:0]            nx_hi_s;
    logic [DATA_WIDTH-1:0] sample_s;
    logic [31:0]           slot_word_s;

    // Input FSM, frame load and next-state of the free-running counter.
    always_comb begin
        cnt_d      = cnt_q + 9'd1;
        state_d    = state_q;
        hold_l_d   = hold_l_q;
        hold_r_d   = hold_r_q;
        frame_l_d  = frame_l_q;
        frame_r_d  = frame_r_q;
        underrun_d = 1'b0;
        sync_err_d = 1'b0;
        hs_s       = s_axis_valid & ready_q;

        if (hs_s) begin
            case (state_q)
                ST_FILL_L: begin
                    if (!s_axis_last) begin
                        hold_l_d = s_axis_data;
                        state_d  = ST_FILL_R;
                    end else begin
                        // Right word without a left word: drop it.
                        sync_err_d = 1'b1;
                    end
                end
                ST_FILL_R: begin
                    if (s_axis_last) begin
                        hold_r_d = s_axis_data;
                        state_d  = ST_FULL;
                    end else begin
                        // Second left word: treat it as the new left sample.
                        hold_l_d   = s_axis_data;
                        sync_err_d = 1'b1;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        // Frame load looks only at the registered state, so a pair completed
        // on this very clock is held for the following frame.
        if (cnt_q == 9'd511) begin
            if (state_q == ST_FULL) begin
                frame_l_d = hold_l_q;
                frame_r_d = hold_r_q;
                state_d   = ST_FILL_L;
            end else begin
                frame_l_d  = '0;
                frame_r_d  = '0;
                underrun_d = 1'b1;
            end
        end else begin
            underrun_d = 1'b0;
        end

        ready_d = (state_d != ST_FULL);
    end

    // Serialiser: pick the bit for the count value that follows this edge.
    always_comb begin
        // Only consulted when cnt_q[2:0]==7, where +1 carries into bit 3.
        nx_hi_s     = cnt_q[8:3] + 6'd1;
        sample_s    = nx_hi_s[5] ? frame_r_q : frame_l_q;
        // Slot 0 carries the I2S delay bit and slots past the sample are zero.
        slot_word_s = 32'({1'b0, sample_s}) << PAD;
        if (cnt_q[2:0] == 3'd7) begin
            // 31 - slot is the bitwise inverse of a 5-bit slot number.
            sdout_d = slot_word_s[~nx_hi_s[4:0]];
        end else begin
            sdout_d = sdout_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= 9'd0;
            state_q    <= ST_FILL_L;
            ready_q    <= 1'b1;
            hold_l_q   <= '0;
            hold_r_q   <= '0;
            frame_l_q  <= '0;
            frame_r_q  <= '0;
            sdout_q    <= 1'b0;
            underrun_q <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            ready_q    <= ready_d;
            hold_l_q   <= hold_l_d;
            hold_r_q   <= hold_r_d;
            frame_l_q  <= frame_l_d;
            frame_r_q  <= frame_r_d;
            sdout_q    <= sdout_d;
            underrun_q <= underrun_d;
            sync_err_q <= sync_err_d;
        end
    end

    assign s_axis_ready = ready_q;
    assign tx_lrck      = cnt_q[8];
    assign tx_sclk      = cnt_q[2];
    assign tx_sdout     = sdout_q;
    assign underrun     = underrun_q;
    assign sync_err     = sync_err_q;

endmodule

// File: tb/tb_axis_i2s_tx.sv
// ---------------------------------------------------------------------------
// tb_axis_i2s_tx
//   Self-checking bench for axis_i2s_tx. Completed pairs go into a pending
//   queue when their right word is handed over; at each frame boundary the
//   bench decides which frame (pair or mute) must play and compares the
//   captured 64 slot bits, the underrun pulse, ready and the clock pins.
// ---------------------------------------------------------------------------
module tb_axis_i2s_tx;

    logic        clk;
    logic        reset;
    logic [23:0] s_axis_data;
    logic        s_axis_valid;
    logic        s_axis_ready;
    logic        s_axis_last;
    logic        tx_lrck;
    logic        tx_sclk;
    logic        tx_sdout;
    logic        underrun;
    logic        sync_err;

    axis_i2s_tx #(.DATA_WIDTH(24)) dut (
        .clk          (clk),
        .reset        (reset),
        .s_axis_data  (s_axis_data),
        .s_axis_valid (s_axis_valid),
        .s_axis_ready (s_axis_ready),
        .s_axis_last  (s_axis_last),
        .tx_lrck      (tx_lrck),
        .tx_sclk      (tx_sclk),
        .tx_sdout     (tx_sdout),
        .underrun     (underrun),
        .sync_err     (sync_err)
    );

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        int          hs_cyc;
    } pair_t;

    pair_t       pend[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          sync_cnt = 0;
    logic [8:0]  tb_cnt;
    int          cyc;
    logic [63:0] cap;
    logic [63:0] cur_exp;
    logic        cap_valid = 1'b0;
    logic        started = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference frame counter, independent of the DUT.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            tb_cnt <= 9'd0;
            cyc    <= 0;
        end else begin
            tb_cnt <= tb_cnt + 9'd1;
            cyc    <= cyc + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected slot bits: slot s of a channel carries sample[24-s], s=1..24.
    function automatic logic [63:0] build(input logic [23:0] l, input logic [23:0] r);
        logic [63:0] f;
        f = 64'd0;
        for (int s = 1; s <= 24; s++) begin
            f[s]      = l[24-s];
            f[32 + s] = r[24-s];
        end
        return f;
    endfunction

    // Frame monitor / scoreboard.
    initial begin
        pair_t p;
        int    c511;
        logic  exp_ur;
        forever begin
            @(negedge clk);
            if (reset) begin
                pend.delete();
                started   = 1'b0;
                cap_valid = 1'b0;
            end else begin
                check_eq("pins", 64'({tx_lrck, tx_sclk}), 64'({tb_cnt[8], tb_cnt[2]}));
                if (sync_err) sync_cnt++;
                if (tb_cnt[2:0] == 3'd4) cap[{tb_cnt[8], tb_cnt[7:3]}] = tx_sdout;
                if (tb_cnt == 9'd0) begin
                    c511 = cyc - 1;
                    if (!started) begin
                        started = 1'b1;
                        cur_exp = 64'd0;
                        exp_ur  = 1'b0;
                    end else if (pend.size() > 0 && pend[0].hs_cyc < c511) begin
                        p       = pend.pop_front();
                        cur_exp = build(p.l, p.r);
                        exp_ur  = 1'b0;
                        check_eq("ready_rise", 64'(s_axis_ready), 64'd1);
                    end else begin
                        cur_exp = 64'd0;
                        exp_ur  = 1'b1;
                    end
                    check_eq("underrun", 64'(underrun), 64'(exp_ur));
                    cap_valid = 1'b1;
                end
                if (tb_cnt == 9'd1) check_eq("underrun_w", 64'(underrun), 64'd0);
                if (tb_cnt == 9'd511) begin
                    if (cap_valid) check_eq("frame", cap, cur_exp);
                    if (pend.size() > 0 && pend[0].hs_cyc < cyc)
                        check_eq("ready_full", 64'(s_axis_ready), 64'd0);
                end
            end
        end
    end

    // Called on a negedge; returns on the negedge after the handshake.
    task automatic send_word(input logic [23:0] d, input logic last,
                             input logic push, input logic [23:0] pl);
        logic ok;
        pair_t p;
        ok = 1'b0;
        s_axis_data  = d;
        s_axis_last  = last;
        s_axis_valid = 1'b1;
        for (int n = 0; n < 3000 && !ok; n++) begin
            if (s_axis_ready) begin
                ok = 1'b1;
                if (push) begin
                    p.l = pl;
                    p.r = d;
                    p.hs_cyc = cyc;
                    pend.push_back(p);
                end
            end
            @(negedge clk);
        end
        check_eq("hs_done", 64'(ok), 64'd1);
        if (push && ok) check_eq("ready_drop", 64'(s_axis_ready), 64'd0);
    endtask

    task automatic send_pair(input logic [23:0] l, input logic [23:0] r);
        send_word(l, 1'b0, 1'b0, 24'd0);
        send_word(r, 1'b1, 1'b1, l);
    endtask

    task automatic wait_cnt(input logic [8:0] v);
        for (int n = 0; n < 2000 && tb_cnt != v; n++) @(negedge clk);
        check_eq("wait_cnt", 64'(tb_cnt), 64'(v));
    endtask

    task automatic wait_frames(input int k);
        repeat (k * 512) @(negedge clk);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int s0;
        reset        = 1'b1;
        s_axis_data  = 24'd0;
        s_axis_valid = 1'b0;
        s_axis_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_outs",
                 64'({tx_lrck, tx_sclk, tx_sdout, underrun, sync_err, s_axis_ready}),
                 64'(6'b000001));
        release_reset();

        // 1: one pair, checked bit by bit in the next frame.
        send_pair(24'h800001, 24'h7FFFFE);
        s_axis_valid = 1'b0;
        wait_frames(2);

        // 2: idle frames -> mute + underrun each frame.
        wait_frames(3);

        // 3: valid held high over three pairs.
        send_pair(24'hA5C3E1, 24'h123456);
        send_pair(24'h0F0F0F, 24'hFFFFFF);
        send_pair(24'h000001, 24'hC00000);
        s_axis_valid = 1'b0;
        wait_frames(4);
        check_eq("sync_none", 64'(sync_cnt), 64'd0);

        // 4: framing violations.
        s0 = sync_cnt;
        send_word(24'h000111, 1'b1, 1'b0, 24'd0);
        send_word(24'h000222, 1'b0, 1'b0, 24'd0);
        send_word(24'h000333, 1'b0, 1'b0, 24'd0);
        send_word(24'h000444, 1'b1, 1'b1, 24'h000333);
        s_axis_valid = 1'b0;
        wait_frames(2);
        check_eq("sync_pulses", 64'(sync_cnt - s0), 64'd2);

        // 5: right word handed over on the cnt==511 clock.
        wait_cnt(9'd20);
        send_word(24'h5A5A5A, 1'b0, 1'b0, 24'd0);
        s_axis_valid = 1'b0;
        wait_cnt(9'd511);
        send_word(24'h3C3C3C, 1'b1, 1'b1, 24'h5A5A5A);
        s_axis_valid = 1'b0;
        wait_frames(3);

        // 6: reset mid-frame with a pair queued.
        wait_cnt(9'd10);
        send_pair(24'hFEDCBA, 24'h987654);
        s_axis_valid = 1'b0;
        wait_cnt(9'd299);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check_eq("rst_mid",
                 64'({tx_lrck, tx_sclk, tx_sdout, underrun, sync_err, s_axis_ready}),
                 64'(6'b000001));
        repeat (3) @(posedge clk);
        release_reset();
        wait_frames(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
